// File: rtl/nand_xor_comp_4_2_row_pkg.sv
// Shared constants and helpers for the 4:2 compressor row.
package nand_xor_comp_4_2_row_pkg;

    localparam int unsigned WIDTH_DEFAULT = 16;

    // xor=1 with nand=0 would mean i0^i1=1 and i0&i1=1 at once, which cannot happen.
    function automatic logic is_illegal_enc(input logic x, input logic n);
        return x & ~n;
    endfunction

endpackage

// File: rtl/nand_xor_comp_4_2_row_cell.sv
// One combinational 4:2 compressor lane fed with pre-encoded i0/i1.
module nx_comp42_cell (
    input  logic i0_xor_i1,
    input  logic i0_nand_i1,
    input  logic i2,
    input  logic i3,
    input  logic ci,
    output logic co,
    output logic c,
    output logic d
);

    logic t;

    // co depends only on i0/i1/i2, so the horizontal chain is one mux deep per lane.
    assign co = i0_xor_i1 ? i2 : ~i0_nand_i1;
    assign t  = i0_xor_i1 ^ i2 ^ i3;
    assign d  = t ^ ci;
    assign c  = t ? ci : i3;

endmodule

// File: rtl/nand_xor_comp_4_2_row.sv
// Registered row of WIDTH 4:2 compressor lanes with lane-to-lane co->ci chaining.
module nand_xor_comp_4_2_row
    import nand_xor_comp_4_2_row_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] i0_xor_i1,
    input  logic [WIDTH-1:0] i0_nand_i1,
    input  logic [WIDTH-1:0] i2,
    input  logic [WIDTH-1:0] i3,
    input  logic             ci_in,
    output logic             out_valid,
    output logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] c,
    output logic             co_out,
    output logic             enc_err
);

    logic [WIDTH:0]   ci_chain;
    logic [WIDTH-1:0] sum_comb;
    logic [WIDTH-1:0] carry_comb;
    logic [WIDTH-1:0] illegal_vec;

    assign ci_chain[0] = ci_in;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_lane
            nx_comp42_cell u_cell (
                .i0_xor_i1  (i0_xor_i1[gi]),
                .i0_nand_i1 (i0_nand_i1[gi]),
                .i2         (i2[gi]),
                .i3         (i3[gi]),
                .ci         (ci_chain[gi]),
                .co         (ci_chain[gi+1]),
                .c          (carry_comb[gi]),
                .d          (sum_comb[gi])
            );
            assign illegal_vec[gi] = is_illegal_enc(i0_xor_i1[gi], i0_nand_i1[gi]);
        end
    endgenerate

    logic             valid_q;
    logic [WIDTH-1:0] sum_q,   sum_d;
    logic [WIDTH-1:0] carry_q, carry_d;
    logic             co_q,    co_d;
    logic             err_q,   err_d;

    // Result registers only load on accepted vectors; otherwise they hold.
    always_comb begin
        sum_d   = sum_q;
        carry_d = carry_q;
        co_d    = co_q;
        err_d   = err_q;
        if (in_valid) begin
            sum_d   = sum_comb;
            carry_d = carry_comb;
            co_d    = ci_chain[WIDTH];
            err_d   = |illegal_vec;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            valid_q <= 1'b0;
            sum_q   <= '0;
            carry_q <= '0;
            co_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            valid_q <= in_valid;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            co_q    <= co_d;
            err_q   <= err_d;
        end
    end

    assign out_valid = valid_q;
    assign d         = sum_q;
    assign c         = carry_q;
    assign co_out    = co_q;
    assign enc_err   = err_q;

endmodule

// File: tb/tb_nand_xor_comp_4_2_row.sv
// Scoreboard bench for the 4:2 compressor row: driver pushes expectations, monitor pops on out_valid.
module tb_nand_xor_comp_4_2_row;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic [W-1:0] x_in = '0;
    logic [W-1:0] n_in = '1;
    logic [W-1:0] p_in = '0;
    logic [W-1:0] q_in = '0;
    logic         ci = 1'b0;
    logic         out_valid;
    logic [W-1:0] d_out;
    logic [W-1:0] c_out;
    logic         co_out;
    logic         enc_err;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [W-1:0] d;
        logic [W-1:0] c;
        logic         co;
        logic         err;
        int           total;
    } exp_t;

    exp_t sb[$];
    exp_t last_exp;
    logic valid_d;

    nand_xor_comp_4_2_row #(.WIDTH(W)) dut (
        .sys_clk    (clk),
        .sys_rst_n  (rst_n),
        .in_valid   (in_valid),
        .i0_xor_i1  (x_in),
        .i0_nand_i1 (n_in),
        .i2         (p_in),
        .i3         (q_in),
        .ci_in      (ci),
        .out_valid  (out_valid),
        .d          (d_out),
        .c          (c_out),
        .co_out     (co_out),
        .enc_err    (enc_err)
    );

    always #5 clk = ~clk;

    // Arithmetic reference: co is the majority of i0,i1,i2; d and c follow from the lane sum.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic [W-1:0] p, input logic [W-1:0] q,
                                   input logic cin, input logic err);
        exp_t e;
        int   carry;
        int   s3;
        int   s;
        int   cok;
        int   tot;
        carry = int'(cin);
        tot   = int'(cin);
        for (int k = 0; k < W; k++) begin
            s3  = int'(a[k]) + int'(b[k]) + int'(p[k]);
            s   = s3 + int'(q[k]) + carry;
            cok = (s3 >= 2) ? 1 : 0;
            e.d[k] = s[0];
            e.c[k] = ((s - (s & 1) - 2 * cok) / 2) != 0;
            carry  = cok;
            tot    = tot + ((s3 + int'(q[k])) << k);
        end
        e.co    = carry[0];
        e.err   = err;
        e.total = tot;
        return e;
    endfunction

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    // illegal marks lanes driven with xor=1, nand=0; the model treats them as i0=1, i1=0.
    task automatic drive(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] p, input logic [W-1:0] q, input logic cin,
                         input logic [W-1:0] illegal);
        logic [W-1:0] am;
        logic [W-1:0] bm;
        exp_t e;
        @(posedge clk);
        #1;
        in_valid = v;
        x_in = (a ^ b) | illegal;
        n_in = ~(a & b) & ~illegal;
        p_in = p;
        q_in = q;
        ci   = cin;
        if (v) begin
            am = a | illegal;
            bm = b & ~illegal;
            e = model(am, bm, p, q, cin, |illegal);
            sb.push_back(e);
            last_exp = e;
            $display("drive a=%04h b=%04h p=%04h q=%04h ci=%0d ill=%04h -> d=%04h c=%04h co=%0d err=%0d",
                     a, b, p, q, cin, illegal, e.d, e.c, e.co, e.err);
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) valid_d <= 1'b0;
        else        valid_d <= in_valid;
    end

    always @(negedge clk) begin
        exp_t e;
        int   sum_out;
        if (rst_n) begin
            check("out_valid", int'(out_valid), int'(valid_d));
            if (out_valid) begin
                if (sb.size() == 0) begin
                    check("unexpected_output", 1, 0);
                end else begin
                    e = sb.pop_front();
                    sum_out = int'(d_out) + 2 * int'(c_out) + (int'(co_out) << W);
                    check("d", int'(d_out), int'(e.d));
                    check("c", int'(c_out), int'(e.c));
                    check("co_out", int'(co_out), int'(e.co));
                    check("enc_err", int'(enc_err), int'(e.err));
                    check("row_identity", sum_out, e.total);
                end
            end
        end
    end

    initial begin
        logic [3:0] v4;
        #3;
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_outputs", int'({d_out, c_out, co_out, enc_err}), 0);
        @(posedge clk);
        #2 rst_n = 1'b1;

        // Exhaustive single lane on lane 0, remaining lanes idle.
        for (int cv = 0; cv < 2; cv++) begin
            for (int v = 0; v < 16; v++) begin
                v4 = 4'(v);
                drive(1'b1, {15'b0, v4[3]}, {15'b0, v4[2]}, {15'b0, v4[1]}, {15'b0, v4[0]},
                      1'(cv), '0);
            end
        end

        // Full ripple: every lane sums to 5.
        drive(1'b1, '1, '1, '1, '1, 1'b1, '0);
        sb[sb.size()-1].d  = 16'hFFFF;
        sb[sb.size()-1].c  = 16'hFFFF;
        sb[sb.size()-1].co = 1'b1;
        sb[sb.size()-1].total = 4 * 65535 + 1;

        // Illegal encoding on lane 5, then a legal vector clears enc_err.
        drive(1'b1, 16'h0003, 16'h0001, 16'h0020, 16'h0100, 1'b0, 16'h0020);
        drive(1'b1, 16'h00F0, 16'h0F00, 16'h1234, 16'h8001, 1'b1, '0);

        // Hold: outputs freeze while in_valid is low.
        drive(1'b1, 16'hA5A5, 16'h5A5A, 16'hFF00, 16'h0F0F, 1'b1, '0);
        drive(1'b0, '0, '0, '0, '0, 1'b0, '0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #2;
            check("hold_out_valid", int'(out_valid), 0);
            check("hold_d", int'(d_out), int'(last_exp.d));
            check("hold_c", int'(c_out), int'(last_exp.c));
            check("hold_co", int'(co_out), int'(last_exp.co));
        end

        // Mid-stream asynchronous reset between clock edges.
        drive(1'b1, 16'hFFFF, 16'h0000, 16'hFFFF, 16'hFFFF, 1'b1, '0);
        drive(1'b0, '0, '0, '0, '0, 1'b0, '0);
        @(negedge clk);
        #1;
        check("pre_rst_valid", int'(out_valid), 1);
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", int'(out_valid), 0);
        check("async_rst_outputs", int'({d_out, c_out, co_out, enc_err}), 0);
        sb.delete();
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b1;
        drive(1'b1, 16'h0101, 16'h1010, 16'h00FF, 16'hF000, 1'b0, '0);
        drive(1'b0, '0, '0, '0, '0, 1'b0, '0);
        #1;
        check("post_rst_latency", int'(out_valid), 1);
        check("post_rst_d", int'(d_out), int'(last_exp.d));

        // Random legal vectors with random valid gaps.
        for (int i = 0; i < 10000; i++) begin
            drive(1'($urandom_range(0, 3) != 0), 16'($urandom), 16'($urandom), 16'($urandom),
                  16'($urandom), 1'($urandom), '0);
        end
        drive(1'b0, '0, '0, '0, '0, 1'b0, '0);

        for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
        check("scoreboard_drained", sb.size(), 0);
        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/nand_xor_comp_4_2_row.md
Name: nand_xor_comp_4_2_row

Overview:
- Registered row of WIDTH 4:2 compressor lanes for the Wallace-tree partial-product reduction of the Booth-4 multiplier.
- Operand pair i0/i1 of each lane arrives pre-encoded as i0^i1 and ~(i0&i1), produced by the upstream Booth stage. Operands i2, i3 and the row carry-in arrive raw.
- Lane carry-out co ripples horizontally into the next lane's ci. Sum d and carry c are registered with one-cycle latency for the next tree level.

Parameters:
- WIDTH, 16, number of compressor lanes (bit columns); legal range 1..64.

Ports:
- sys_clk     input   1      clock; all state updates on rising edge
- sys_rst_n   input   1      asynchronous active-low reset
- in_valid    input   1      input vector qualifier
- i0_xor_i1   input   WIDTH  per-lane i0 ^ i1
- i0_nand_i1  input   WIDTH  per-lane ~(i0 & i1)
- i2          input   WIDTH  per-lane third operand bit
- i3          input   WIDTH  per-lane fourth operand bit
- ci_in       input   1      carry-in to lane 0
- out_valid   output  1      registered in_valid
- d           output  WIDTH  per-lane sum bit, weight 2^k
- c           output  WIDTH  per-lane carry bit, weight 2^(k+1)
- co_out      output  1      co of lane WIDTH-1, weight 2^WIDTH
- enc_err     output  1      registered flag: illegal i0/i1 encoding seen

Behaviour:
- Lane k logic, combinational, with ci_0 = ci_in and ci_k = co_(k-1):
  - co_k = i0_xor_i1[k] ? i2[k] : ~i0_nand_i1[k]. This is the carry of i0, i1 and i2; it is independent of ci_k, so there is no long ripple dependency.
  - t_k = i0_xor_i1[k] ^ i2[k] ^ i3[k]
  - d[k] = t_k ^ ci_k
  - c[k] = t_k ? ci_k : i3[k]
- Per-lane identity: i0+i1+i2+i3+ci_k = d[k] + 2*(c[k] + co_k).
- Row identity: Σ(i0+i1+i2+i3)[k]·2^k + ci_in = Σd[k]·2^k + Σc[k]·2^(k+1) + co_out·2^WIDTH.
- Illegal encoding in a lane is i0_xor_i1=1 with i0_nand_i1=0.
  - The lane math still follows the equations above; the nand input is ignored when xor=1.
  - enc_err asserts for the cycle following any accepted illegal lane.
- Registering:
  - On a rising edge with in_valid=1, d, c, co_out and enc_err capture the combinational results, and out_valid goes to 1.
  - On a rising edge with in_valid=0, out_valid goes to 0 and d, c, co_out and enc_err hold their values.
  - Latency is exactly 1 cycle. Back-to-back valid inputs give back-to-back outputs. There is no backpressure.
- Reset: while sys_rst_n=0, out_valid, d, c, co_out and enc_err are all 0 immediately, regardless of clock. Reset asserted mid-stream drops any in-flight result. The first capture occurs on the first rising edge after deassertion.
- No X propagation: every output is defined for all 2^(4·WIDTH+1) input combinations.

Decomposition:
- No shared package needed; WIDTH is the only constant and is passed by parameter.
- One natural sub-module: nx_comp42_cell, a purely combinational single lane with inputs i0_xor_i1, i0_nand_i1, i2, i3, ci and outputs co, c, d.
- The row instantiates WIDTH cells with a generate loop, chains co to ci, ORs the per-lane illegal flags, and adds the output register stage.

Test Plan:
- Exhaustive single lane (WIDTH=1), driven from raw i0/i1 encoded by the bench:
  - Stimulus: ci_in=0 then 1, {i0,i1,i2,i3} stepping 0000..1111, 32 vectors, in_valid=1.
  - Required: each output satisfies the per-lane identity one cycle later. Sample values: 1111 with ci=1 -> d=1, c=1, co=1; 0000 with ci=0 -> all 0; 1000 with ci=1 -> d=0, c=1, co=0.
  - Required: enc_err=0 throughout.
- Ripple across lanes (WIDTH=16):
  - Stimulus: all i0..i3 = 1, ci_in = 1.
  - Required: every lane co=1 with d=1 and c=1, co_out=1, and the row identity holds (65·... sum check).
- Random row: 10k random legal vectors, WIDTH=16 -> row identity holds every cycle, out_valid matches in_valid delayed by 1.
- Illegal encoding:
  - Stimulus: lane 5 driven with i0_xor_i1=1 and i0_nand_i1=0, with in_valid=1.
  - Required: enc_err=1 the next cycle, and lane 5 d/c/co are computed with nand ignored.
  - Then drive a legal vector: enc_err returns to 0.
- Reset:
  - Stimulus: assert sys_rst_n=0 between clock edges while out_valid=1 and outputs are nonzero.
  - Required: all outputs go to 0 immediately.
  - Deassert and apply a valid vector: the result appears 1 cycle after the first valid edge.
- Hold: in_valid=0 for 3 cycles after a valid vector -> d, c and co_out are unchanged, and out_valid=0.
